// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider: registered square wave `q` and
// period strobe `tick` at f(clk)/N. Define CLKDIV_IMMEDIATE_LOAD_EN to apply loads at once.
module clkdiv_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] div_in,
  output logic             q,
  output logic             tick,
  output logic             pending,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] RESET_N = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] n_reg, n_next;
  logic [WIDTH-1:0] p_reg, p_next;
  logic             run_reg;
  logic             q_reg, q_next;
  logic             tick_reg, tick_next;
  logic             boundary;

`ifndef CLKDIV_IMMEDIATE_LOAD_EN
  logic [WIDTH-1:0] pend_div_reg, pend_div_next;
  logic             pend_reg, pend_next;
`endif

  // The first edge out of reset counts as a boundary so that it enters phase 0
  // instead of advancing from it; N of 0 or 1 makes every edge a boundary.
  always_comb begin
    boundary = !run_reg || (n_reg <= ONE) || (p_reg == n_reg - ONE);
  end

`ifdef CLKDIV_IMMEDIATE_LOAD_EN
  always_comb begin
    n_next = n_reg;
    p_next = '0;
    if (load) begin
      n_next = div_in;
    end else if (!boundary) begin
      p_next = p_reg + ONE;
    end
  end

  assign pending = 1'b0;
`else
  always_comb begin
    n_next        = n_reg;
    p_next        = '0;
    pend_div_next = pend_div_reg;
    pend_next     = pend_reg;
    if (boundary) begin
      // A load on the boundary edge beats any older pending value.
      if (load) begin
        n_next = div_in;
      end else if (pend_reg) begin
        n_next = pend_div_reg;
      end
      pend_next = 1'b0;
    end else begin
      p_next = p_reg + ONE;
      if (load) begin
        pend_div_next = div_in;
        pend_next     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_div_reg <= '0;
      pend_reg     <= 1'b0;
    end else begin
      pend_div_reg <= pend_div_next;
      pend_reg     <= pend_next;
    end
  end

  assign pending = pend_reg;
`endif

  // Decode from the next phase so the registered outputs line up with p_reg.
  always_comb begin
    q_next    = (p_next < (n_next >> 1));
    tick_next = (n_next != '0) && (p_next == n_next - ONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_reg    <= RESET_N;
      p_reg    <= '0;
      run_reg  <= 1'b0;
      q_reg    <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      n_reg    <= n_next;
      p_reg    <= p_next;
      run_reg  <= 1'b1;
      q_reg    <= q_next;
      tick_reg <= tick_next;
    end
  end

  assign q          = q_reg;
  assign tick       = tick_reg;
  assign div_active = n_reg;

endmodule
